// File: rtl/tcp_tx_scheduler.sv
// Orders SYN/ACK/FIN/RST and data segments of one TCP connection onto the encoder; optional TCP_ACK_DELAY_EN holds pure ACKs.
// Latency: descriptor valid the cycle after selection in IDLE; minimum 3 cycles per segment.
// Backpressure: descriptor held stable until tx_ready_i, then waits for tx_done_i or TIMEOUT.
module tcp_tx_scheduler #(
    parameter int TIMEOUT   = 4096,
    parameter int ACK_DELAY = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_syn_i,
    input  logic        req_ack_i,
    input  logic        req_fin_i,
    input  logic        req_rst_i,
    input  logic        data_req_i,
    input  logic [15:0] data_addr_i,
    input  logic [15:0] data_size_i,
    output logic        data_grant_o,
    input  logic [31:0] snd_nxt_i,
    input  logic [31:0] rcv_nxt_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  tx_flags_o,
    output logic [31:0] tx_seq_o,
    output logic [31:0] tx_ack_o,
    output logic [15:0] tx_payload_addr_o,
    output logic [15:0] tx_payload_size_o,
    input  logic        tx_done_i,
    output logic        busy_o,
    output logic        err_timeout_o,
    output logic [3:0]  pending_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2} state_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_RST, SEL_SYN, SEL_FIN, SEL_DATA, SEL_ACK} sel_t;

    state_t        state_q;
    sel_t          sel;
    logic [3:0]    pend_q, pend_d, clr;
    logic          ack_ok;
    logic [TW-1:0] to_cnt_q;
    logic          is_data_q;
    logic          tx_valid_q, grant_q, err_q;
    logic [7:0]    tx_flags_q;
    logic [31:0]   tx_seq_q, tx_ack_q;
    logic [15:0]   tx_addr_q, tx_size_q;

    // Pending bits are {rst, fin, syn, ack}; selection only looks at registered bits.
    always_comb begin
        sel = SEL_NONE;
        if (state_q == IDLE) begin
            if (pend_q[3])                 sel = SEL_RST;
            else if (pend_q[1])            sel = SEL_SYN;
            else if (pend_q[2])            sel = SEL_FIN;
            else if (data_req_i)           sel = SEL_DATA;
            else if (pend_q[0] && ack_ok)  sel = SEL_ACK;
        end
    end

    always_comb begin
        clr = 4'b0000;
        case (sel)
            SEL_RST:  clr = 4'b1111;
            SEL_SYN:  clr = 4'b0011;
            SEL_FIN:  clr = 4'b0101;
            SEL_DATA: clr = 4'b0001;
            SEL_ACK:  clr = 4'b0001;
            default:  clr = 4'b0000;
        endcase
        // A fresh ACK request survives consumption; SYN/FIN/RST requests are absorbed.
        pend_d = (pend_q & ~clr)
               | ({req_rst_i, req_fin_i, req_syn_i, req_ack_i} & ~(clr & 4'b1110));
    end

`ifdef TCP_ACK_DELAY_EN
    localparam int AW = $clog2(ACK_DELAY + 1);
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;

    always_comb begin
        ack_cnt_d = ack_cnt_q;
        if (!pend_d[0])
            ack_cnt_d = '0;
        else if (!pend_q[0] || clr[0])
            ack_cnt_d = AW'(1);
        else if (ack_cnt_q < AW'(ACK_DELAY - 1))
            ack_cnt_d = ack_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ack_cnt_q <= '0;
        else       ack_cnt_q <= ack_cnt_d;
    end

    assign ack_ok = (ack_cnt_q >= AW'(ACK_DELAY - 1));
`else
    // Pure ACK is eligible at once; ACK_DELAY has no effect in this build.
    assign ack_ok = (ACK_DELAY >= 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            to_cnt_q   <= '0;
            is_data_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            grant_q    <= 1'b0;
            err_q      <= 1'b0;
            tx_flags_q <= '0;
            tx_seq_q   <= '0;
            tx_ack_q   <= '0;
            tx_addr_q  <= '0;
            tx_size_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel != SEL_NONE) begin
                        tx_valid_q <= 1'b1;
                        tx_seq_q   <= snd_nxt_i;
                        tx_ack_q   <= rcv_nxt_i;
                        tx_addr_q  <= '0;
                        tx_size_q  <= '0;
                        is_data_q  <= (sel == SEL_DATA);
                        state_q    <= ISSUE;
                        case (sel)
                            SEL_RST: begin
                                tx_flags_q <= 8'h04;
                                tx_ack_q   <= '0;
                            end
                            SEL_SYN: begin
                                tx_flags_q <= pend_q[0] ? 8'h12 : 8'h02;
                                if (!pend_q[0]) tx_ack_q <= '0;
                            end
                            SEL_FIN:  tx_flags_q <= 8'h11;
                            SEL_DATA: begin
                                tx_flags_q <= 8'h18;
                                tx_addr_q  <= data_addr_i;
                                tx_size_q  <= data_size_i;
                            end
                            default:  tx_flags_q <= 8'h10;
                        endcase
                    end
                end
                ISSUE: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        grant_q    <= is_data_q;
                        to_cnt_q   <= '0;
                        state_q    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_i) begin
                        state_q <= IDLE;
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o            = (state_q != IDLE);
    assign pending_o         = pend_q;
    assign tx_valid_o        = tx_valid_q;
    assign tx_flags_o        = tx_flags_q;
    assign tx_seq_o          = tx_seq_q;
    assign tx_ack_o          = tx_ack_q;
    assign tx_payload_addr_o = tx_addr_q;
    assign tx_payload_size_o = tx_size_q;
    assign data_grant_o      = grant_q;
    assign err_timeout_o     = err_q;

endmodule
